ctrl_pipe: RTL
==============

CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 Parameter D_WIDTH, default 32, instruction width; SHALL be at least 32.
REQ-002 Parameter CNT_W, default 16, width of the bubble counter.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 Instr_D  in  D_WIDTH  ID-stage instruction; opcode [6:0], fn3 [14:12], fn7 [31:25].
REQ-006 Stall_D  in  1  hazard stall; insert bubble into EX this cycle.
REQ-007 Zero_E, LT_E, LTU_E  in  1 each  EX-stage ALU flags: equal, signed less-than, unsigned less-than.
REQ-008 ImmSrc_D  out  3  ID-stage immediate type, combinational: I=000, S=001, B=010, J=011, U=100.
REQ-009 ALUControl_E  out  4  ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100, SLT=0101, SLL=0110, SRL=0111, MUL=1000.
REQ-010 ALUSrc_E, JALRctrl_E, PCSrc_E  out  1 each  EX-stage controls; PCSrc_E is the registered branch, jump, or JALR taken decision combined with EX flags.
REQ-011 Flush_D  out  1  equals PCSrc_E; the IF/ID register clears on it.
REQ-012 MemWrite_M, RegWrite_M  out  1 each; ResultSrc_M  out  2.
REQ-013 RegWrite_W  out  1; ResultSrc_W  out  2: ALU=00, MEM=01, PC+4=10, IMM=11.
REQ-014 BubbleCnt  out  CNT_W  count of bubbles inserted, saturating.

Function
REQ-015 Decode SHALL cover these opcodes: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111.
REQ-016 Any other opcode SHALL decode to an all-zero bundle, meaning a NOP: no write, no branch.
REQ-017 R/I-ALU: fn3 000 gives ADD; R with fn7[5]=1 gives SUB; 111 AND, 110 OR, 100 XOR, 010 SLT, 001 SLL, 101 SRL. Other combinations give ADD.
REQ-018 The bundle SHALL be registered through ID/EX, EX/MEM and MEM/WB. Latency ID to EX, EX to MEM, and MEM to WB is 1 cycle each.
REQ-019 Branch resolves in EX on the registered fn3 and the flags:
- 000: Zero.
- 001: !Zero.
- 100: LT.
- 101: !LT.
- 110: LTU.
- 111: !LTU.
- 010 and 011: not taken.
REQ-020 PCSrc_E = (Branch_E AND condition) OR Jump_E OR JALR_E. JALRctrl_E = JALR_E.
REQ-021 If Stall_D=1 or PCSrc_E=1 at a clock edge, ID/EX SHALL load the all-zero bundle (bubble) and BubbleCnt SHALL increment by 1.
REQ-022 Simultaneous stall and flush SHALL insert one bubble and increment once.
REQ-023 BubbleCnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-024 EX/MEM and MEM/WB SHALL never stall; bubbles propagate downstream as NOPs.

Reset
REQ-025 Asserting rst_n low SHALL immediately clear all pipeline registers and BubbleCnt to 0, independent of clk.
REQ-026 While held in reset, all registered outputs are 0, and PCSrc_E and Flush_D are 0.
REQ-027 Reset mid-stream SHALL discard in-flight controls; no write enable survives reset.
REQ-028 The first instruction after deassertion reaches EX one edge later.

Configuration
REQ-029 Macro CTRL_PIPE_MUL_EN:
- Defined: R-type with fn7=0000001 and fn3=000 decodes to MUL (1000), RegWrite=1, ResultSrc=00.
- Undefined: that encoding decodes as a NOP bundle. MUL (1000) is never produced.

Verification
REQ-030 add x1,x2,x3 (0x003100B3): one edge later ALUControl_E=0000, ALUSrc_E=0; two edges later RegWrite_M=1; three edges later RegWrite_W=1, ResultSrc_W=00.
REQ-031 beq with Zero_E=1 in EX: PCSrc_E=1 and Flush_D=1; next edge ID/EX bubble; BubbleCnt goes 0 to 1. Same instruction with Zero_E=0: PCSrc_E=0.
REQ-032 bltu with LTU_E=1: PCSrc_E=1. bge with LT_E=1: PCSrc_E=0.
REQ-033 Stall_D=1 for 3 cycles on lw: three bubbles, BubbleCnt=3. lw then reaches EX with ResultSrc=01 propagating to ResultSrc_W=01.
REQ-034 CNT_W=2, 5 consecutive stalls: BubbleCnt holds at 3. Drop rst_n mid-stream: all outputs 0 immediately, before the next clk edge.
REQ-035 mul x1,x2,x3 (0x023100B3): ALUControl_E=1000 with CTRL_PIPE_MUL_EN defined; all-zero bundle without it.

Source files
------------

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: control-path decoder and ID/EX, EX/MEM, MEM/WB control pipeline
// for a five-stage RISC-V style core. It resolves branches and jumps in EX,
// inserts bubbles on stall or flush, and counts them in a saturating counter.
// Optional feature: define CTRL_PIPE_MUL_EN to decode R-type MUL
// (fn7=0000001, fn3=000). Without it, that encoding decodes as a NOP.
module ctrl_pipe #(
  parameter int D_WIDTH = 32,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [D_WIDTH-1:0] Instr_D,
  input  logic               Stall_D,
  input  logic               Zero_E,
  input  logic               LT_E,
  input  logic               LTU_E,
  output logic [2:0]         ImmSrc_D,
  output logic [3:0]         ALUControl_E,
  output logic               ALUSrc_E,
  output logic               JALRctrl_E,
  output logic               PCSrc_E,
  output logic               Flush_D,
  output logic               MemWrite_M,
  output logic               RegWrite_M,
  output logic [1:0]         ResultSrc_M,
  output logic               RegWrite_W,
  output logic [1:0]         ResultSrc_W,
  output logic [CNT_W-1:0]   BubbleCnt
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010,
    ALU_OR  = 4'b0011, ALU_XOR = 4'b0100, ALU_SLT = 4'b0101,
    ALU_SLL = 4'b0110, ALU_SRL = 4'b0111, ALU_MUL = 4'b1000
  } alu_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011, IMM_U = 3'b100
  } imm_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00, RES_MEM = 2'b01, RES_PC4 = 2'b10, RES_IMM = 2'b11
  } res_e;

  // Control bundle carried through ID/EX. All-zero is a bubble (NOP).
  typedef struct packed {
    logic       reg_write;
    res_e       result_src;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic       alu_src;
    alu_e       alu_control;
    logic [2:0] fn3;
  } ctrl_t;

  logic [6:0] opcode;
  logic [2:0] fn3;
  logic [6:0] fn7;
  logic       is_mul;
  alu_e       alu_arith;
  imm_e       imm_src;
  ctrl_t      dec;
  ctrl_t      id_ex;
  logic       cond;
  logic       bubble;

  assign opcode = Instr_D[6:0];
  assign fn3    = Instr_D[14:12];
  assign fn7    = Instr_D[31:25];
  assign is_mul = (fn7 == 7'b0000001) && (fn3 == 3'b000);

  // Register-address and immediate bits are irrelevant to control decode.
  logic unused_instr;
  if (D_WIDTH > 32) begin : g_wide
    assign unused_instr = ^{Instr_D[D_WIDTH-1:32], Instr_D[24:15], Instr_D[11:7]};
  end else begin : g_narrow
    assign unused_instr = ^{Instr_D[24:15], Instr_D[11:7]};
  end

  // ALU operation shared by R-type and I-ALU; SUB only for R-type with fn7[5].
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    alu_arith = ALU_ADD;
    case (fn3)
      3'b000:  alu_arith = (opcode == OP_R && fn7[5]) ? ALU_SUB : ALU_ADD;
      3'b111:  alu_arith = ALU_AND;
      3'b110:  alu_arith = ALU_OR;
      3'b100:  alu_arith = ALU_XOR;
      3'b010:  alu_arith = ALU_SLT;
      3'b001:  alu_arith = ALU_SLL;
      3'b101:  alu_arith = ALU_SRL;
      default: alu_arith = ALU_ADD;
    endcase
  end

  // Main decoder: opcode to control bundle and immediate type.
  always_comb begin
    dec     = '0;
    imm_src = IMM_I;
    case (opcode)
      OP_R: begin
        if (is_mul) begin
`ifdef CTRL_PIPE_MUL_EN
          dec.reg_write   = 1'b1;
          dec.alu_control = ALU_MUL;
`else
          dec = '0;
`endif
        end else begin
          dec.reg_write   = 1'b1;
          dec.alu_control = alu_arith;
        end
      end
      OP_I: begin
        dec.reg_write   = 1'b1;
        dec.alu_src     = 1'b1;
        dec.alu_control = alu_arith;
      end
      OP_LOAD: begin
        dec.reg_write  = 1'b1;
        dec.result_src = RES_MEM;
        dec.alu_src    = 1'b1;
      end
      OP_STORE: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        imm_src       = IMM_S;
      end
      OP_BRANCH: begin
        dec.branch      = 1'b1;
        dec.alu_control = ALU_SUB;
        dec.fn3         = fn3;
        imm_src         = IMM_B;
      end
      OP_JAL: begin
        dec.jump       = 1'b1;
        dec.reg_write  = 1'b1;
        dec.result_src = RES_PC4;
        imm_src        = IMM_J;
      end
      OP_JALR: begin
        dec.jalr       = 1'b1;
        dec.reg_write  = 1'b1;
        dec.result_src = RES_PC4;
        dec.alu_src    = 1'b1;
      end
      OP_LUI: begin
        dec.reg_write  = 1'b1;
        dec.result_src = RES_IMM;
        dec.alu_src    = 1'b1;
        imm_src        = IMM_U;
      end
      default: dec = '0;
    endcase
  end

  assign ImmSrc_D = imm_src;

  // Branch condition from the registered fn3 and the EX-stage ALU flags.
  always_comb begin
    cond = 1'b0;
    case (id_ex.fn3)
      3'b000:  cond = Zero_E;
      3'b001:  cond = ~Zero_E;
      3'b100:  cond = LT_E;
      3'b101:  cond = ~LT_E;
      3'b110:  cond = LTU_E;
      3'b111:  cond = ~LTU_E;
      default: cond = 1'b0;
    endcase
  end

  assign PCSrc_E      = (id_ex.branch & cond) | id_ex.jump | id_ex.jalr;
  assign Flush_D      = PCSrc_E;
  assign JALRctrl_E   = id_ex.jalr;
  assign ALUSrc_E     = id_ex.alu_src;
  assign ALUControl_E = id_ex.alu_control;

  // A stall and a flush in the same cycle still make a single bubble.
  assign bubble = Stall_D | PCSrc_E;

  // ID/EX register: load the decoded bundle, or a bubble on stall/flush.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      id_ex <= '0;
    end else if (bubble) begin
      id_ex <= '0;
    end else begin
      id_ex <= dec;
    end
  end

  // EX/MEM and MEM/WB never stall; bubbles flow through as NOPs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWrite_M  <= 1'b0;
      MemWrite_M  <= 1'b0;
      ResultSrc_M <= 2'b00;
      RegWrite_W  <= 1'b0;
      ResultSrc_W <= 2'b00;
    end else begin
      RegWrite_M  <= id_ex.reg_write;
      MemWrite_M  <= id_ex.mem_write;
      ResultSrc_M <= id_ex.result_src;
      RegWrite_W  <= RegWrite_M;
      ResultSrc_W <= ResultSrc_M;
    end
  end

  // Saturating count of inserted bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      BubbleCnt <= '0;
    end else if (bubble && (BubbleCnt != '1)) begin
      BubbleCnt <= BubbleCnt + CNT_W'(1);
    end
  end

endmodule
